// File: rtl/fetch_branch_unit.sv
// Fetch/branch controller on the consumer side of a non-stalling PC: fetches on even PC, presents on odd.
// Optional taken-branch counter enabled by defining BRANCH_COUNT_EN.
module fetch_branch_unit #(
  parameter int unsigned INSTR_W = 16,
  parameter logic [3:0]  OPC_JMP = 4'hF,
  parameter logic [3:0]  OPC_BRZ = 4'hE
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [15:0]        pc_in,
  input  logic               exec_flag,
  input  logic               cond_flag,
  output logic               mem_req,
  output logic [14:0]        mem_addr,
  input  logic               mem_ready,
  input  logic [INSTR_W-1:0] mem_rdata,
  output logic [INSTR_W-1:0] instr,
  output logic               instr_valid,
  output logic               load_enable,
  output logic [15:0]        load_addr,
  output logic               phase_err,
  output logic [15:0]        branch_count
);

  typedef enum logic [1:0] {FETCH, EXEC, REPLAY} state_t;

  state_t               state;
  logic                 buf_valid;
  logic [14:0]          buf_addr;
  logic [14:0]          saved_addr;
  logic [INSTR_W-1:0]   buf_data;

  logic [14:0]          word_addr;
  logic                 pc_phase_unused;
  logic                 hit;
  logic                 fetch_done;
  logic                 taken;
  logic [INSTR_W-1:0]   fetch_word;

  assign word_addr       = pc_in[15:1];
  assign pc_phase_unused = pc_in[0];

  always_comb begin
    hit        = buf_valid && (buf_addr == word_addr);
    fetch_word = hit ? buf_data : mem_rdata;
    fetch_done = (state == FETCH) && !exec_flag && (hit || mem_ready);
    taken      = (fetch_word[15:12] == OPC_JMP) ||
                 ((fetch_word[15:12] == OPC_BRZ) && cond_flag);
    mem_req    = 1'b0;
    mem_addr   = '0;
    // Gated by reset so the request drops the instant reset asserts.
    if (reset) begin
      case (state)
        FETCH: begin
          if (!exec_flag && !hit) begin
            mem_req  = 1'b1;
            mem_addr = word_addr;
          end
        end
        REPLAY: begin
          mem_req  = 1'b1;
          mem_addr = saved_addr;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= FETCH;
      buf_valid   <= 1'b0;
      buf_addr    <= '0;
      buf_data    <= '0;
      saved_addr  <= '0;
      instr       <= '0;
      instr_valid <= 1'b0;
      load_enable <= 1'b0;
      load_addr   <= '0;
      phase_err   <= 1'b0;
    end else begin
      phase_err <= 1'b0;
      case (state)
        FETCH: begin
          if (exec_flag) begin
            phase_err   <= 1'b1;
            instr_valid <= 1'b0;
            load_enable <= 1'b0;
          end else begin
            buf_valid <= 1'b0;
            if (fetch_done) begin
              instr       <= fetch_word;
              instr_valid <= 1'b1;
              state       <= EXEC;
              load_enable <= taken;
              if (taken) load_addr <= {4'b0, fetch_word[11:0]};
            end else begin
              // Miss: reload the PC to this word so the next fetch phase retries it.
              state       <= REPLAY;
              load_enable <= 1'b1;
              load_addr   <= {1'b0, word_addr};
              saved_addr  <= word_addr;
              instr_valid <= 1'b0;
            end
          end
        end
        EXEC: begin
          state       <= FETCH;
          instr_valid <= 1'b0;
          load_enable <= 1'b0;
        end
        REPLAY: begin
          if (mem_ready) begin
            buf_data  <= mem_rdata;
            buf_addr  <= saved_addr;
            buf_valid <= 1'b1;
          end
          state       <= FETCH;
          load_enable <= 1'b0;
        end
        default: state <= FETCH;
      endcase
    end
  end

`ifdef BRANCH_COUNT_EN
  logic [15:0] branch_cnt;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      branch_cnt <= '0;
    end else if (fetch_done && taken && (branch_cnt != '1)) begin
      branch_cnt <= branch_cnt + 16'd1;
    end
  end

  assign branch_count = branch_cnt;
`else
  assign branch_count = '0;
`endif

endmodule

// File: tb/tb_fetch_branch_unit.sv
// Bench for fetch_branch_unit: PC and memory environment, directed sequences, decode table
// and a randomized run checked against an instruction-trace reference model.
module tb_fetch_branch_unit;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [15:0] pc_in;
  logic        exec_flag;
  logic        cond_flag = 1'b0;
  logic        mem_req;
  logic [14:0] mem_addr;
  logic        mem_ready = 1'b1;
  logic [15:0] mem_rdata;
  logic [15:0] instr;
  logic        instr_valid;
  logic        load_enable;
  logic [15:0] load_addr;
  logic        phase_err;
  logic [15:0] branch_count;

  logic [15:0] mem [32768];
  logic        pc_skip = 1'b0;
  int          n_cmp = 0;
  int          n_bad = 0;

`ifdef BRANCH_COUNT_EN
  localparam bit BC_EN = 1'b1;
`else
  localparam bit BC_EN = 1'b0;
`endif

  fetch_branch_unit #(.INSTR_W(16), .OPC_JMP(4'hF), .OPC_BRZ(4'hE)) dut (
    .clk(clk), .reset(reset), .pc_in(pc_in), .exec_flag(exec_flag), .cond_flag(cond_flag),
    .mem_req(mem_req), .mem_addr(mem_addr), .mem_ready(mem_ready), .mem_rdata(mem_rdata),
    .instr(instr), .instr_valid(instr_valid), .load_enable(load_enable), .load_addr(load_addr),
    .phase_err(phase_err), .branch_count(branch_count)
  );

  always #5 clk = ~clk;

  // PC environment: free-running increment, loads word address << 1 when asked.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) pc_in <= '0;
    else if (load_enable) pc_in <= {load_addr[14:0], 1'b0};
    else pc_in <= pc_in + (pc_skip ? 16'd2 : 16'd1);
  end

  assign exec_flag = pc_in[0];
  assign mem_rdata = mem_ready ? mem[mem_addr] : 16'hDEAD;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s @%0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  task automatic restart();
    reset = 1'b0;
    mem_ready = 1'b1;
    pc_skip = 1'b0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;
  endtask

  task automatic fill_seq();
    for (int i = 0; i < 32768; i++) mem[i] = {4'h1, 12'(i)};
  endtask

  typedef struct {
    logic [15:0] word;
    logic        cond;
    logic        le;
    logic [15:0] la;
    logic [14:0] next;
  } vec_t;

  vec_t vt[9];

  logic [14:0] exp_addr;
  logic [15:0] w;
  logic        tk;
  int          exp_bc, gap, max_gap;
  logic        pe_seen;

  initial begin
    vt[0] = '{16'h1234, 1'b1, 1'b0, 16'h0000, 15'h0001};
    vt[1] = '{16'hF040, 1'b0, 1'b1, 16'h0040, 15'h0040};
    vt[2] = '{16'hF040, 1'b1, 1'b1, 16'h0040, 15'h0040};
    vt[3] = '{16'hE010, 1'b0, 1'b0, 16'h0000, 15'h0001};
    vt[4] = '{16'hE010, 1'b1, 1'b1, 16'h0010, 15'h0010};
    vt[5] = '{16'hEFFF, 1'b1, 1'b1, 16'h0FFF, 15'h0FFF};
    vt[6] = '{16'hFABC, 1'b0, 1'b1, 16'h0ABC, 15'h0ABC};
    vt[7] = '{16'hD123, 1'b1, 1'b0, 16'h0000, 15'h0001};
    vt[8] = '{16'h0000, 1'b1, 1'b0, 16'h0000, 15'h0001};

    // Reset state
    fill_seq();
    reset = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("reset_outs", {instr, instr_valid, load_enable, load_addr, phase_err, mem_req}, 64'h0);
    check("reset_bcount", branch_count, 16'h0);

    // Straight line
    for (int i = 0; i < 32768; i++) mem[i] = 16'h1234;
    restart();
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      if (c % 2 == 0) check("line_req", {mem_req, mem_addr}, {1'b1, 15'(c / 2)});
      check("line_valid", instr_valid, (c % 2) == 1);
      check("line_le", load_enable, 1'b0);
      if (c % 2 == 1) check("line_instr", instr, 16'h1234);
    end

    // Jump at word 2
    fill_seq();
    mem[2] = 16'hF040;
    restart();
    for (int c = 0; c < 7; c++) begin
      @(negedge clk);
      if (c == 5) begin
        check("jmp_load", {load_enable, load_addr}, {1'b1, 16'h0040});
        check("jmp_instr", {instr_valid, instr}, {1'b1, 16'hF040});
      end
      if (c == 6) check("jmp_target", {mem_req, mem_addr}, {1'b1, 15'h0040});
    end

    // BRZ at word 2, both conditions
    for (int k = 0; k < 2; k++) begin
      fill_seq();
      mem[2] = 16'hE010;
      cond_flag = k[0];
      restart();
      for (int c = 0; c < 7; c++) begin
        @(negedge clk);
        if (c == 5) check("brz_le", load_enable, k[0]);
        if (c == 5 && k == 1) check("brz_la", load_addr, 16'h0010);
        if (c == 6) check("brz_next", mem_addr, k == 1 ? 15'h0010 : 15'h0003);
      end
    end
    cond_flag = 1'b0;

    // Single miss at word 5
    fill_seq();
    restart();
    for (int c = 0; c < 15; c++) begin
      @(negedge clk);
      if (c == 11) begin
        check("miss1_load", {load_enable, load_addr}, {1'b1, 16'h0005});
        check("miss1_replay", {mem_req, mem_addr, instr_valid}, {1'b1, 15'h0005, 1'b0});
      end
      if (c == 12) check("miss1_hit", {mem_req, pc_in}, {1'b0, 16'd10});
      if (c == 13) check("miss1_instr", {instr_valid, instr}, {1'b1, 16'h1005});
      if (c == 14) check("miss1_next", {mem_req, mem_addr}, {1'b1, 15'h0006});
      mem_ready = (c != 10);
    end

    // Long miss at word 8
    restart();
    for (int c = 0; c < 25; c++) begin
      @(negedge clk);
      if (c >= 16 && c <= 21) check("miss5_pc", pc_in, (c % 2 == 0) ? 16'd16 : 16'd17);
      if (c >= 17 && c <= 22) check("miss5_novalid", instr_valid, 1'b0);
      if (c == 23) check("miss5_instr", {instr_valid, instr}, {1'b1, 16'h1008});
      if (c == 24) check("miss5_next", {mem_req, mem_addr}, {1'b1, 15'h0009});
      mem_ready = !(c >= 16 && c <= 20);
    end

    // Phase desync: PC skips to odd while unit waits in FETCH
    restart();
    for (int c = 0; c < 7; c++) begin
      @(negedge clk);
      if (c == 4) check("desync_noreq", {mem_req, phase_err}, 2'b00);
      if (c == 5) check("desync_err", {phase_err, instr_valid, mem_req, mem_addr}, {3'b101, 15'h0003});
      if (c == 6) check("desync_recover", {phase_err, instr_valid, instr}, {2'b01, 16'h1003});
      pc_skip = (c == 3);
    end

    // Three taken branches then async reset mid-EXEC
    fill_seq();
    mem[0] = 16'hF002;
    mem[2] = 16'hF004;
    mem[4] = 16'hE006;
    cond_flag = 1'b1;
    restart();
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      if (c == 5) begin
        check("bc_load", {load_enable, load_addr}, {1'b1, 16'h0006});
        check("bc_three", branch_count, BC_EN ? 16'd3 : 16'd0);
      end
    end
    #1 reset = 1'b0;
    #1;
    check("async_outs", {instr, instr_valid, load_enable, load_addr, phase_err, mem_req}, 64'h0);
    check("async_bcount", branch_count, 16'h0);
    @(posedge clk);
    #1 reset = 1'b1;
    @(negedge clk);
    check("async_fetch", {mem_req, mem_addr, instr_valid}, {1'b1, 15'h0000, 1'b0});
    cond_flag = 1'b0;

    // Decode table: one instruction at word 0
    foreach (vt[i]) begin
      fill_seq();
      mem[0] = vt[i].word;
      cond_flag = vt[i].cond;
      restart();
      @(negedge clk);
      @(negedge clk);
      check($sformatf("tbl%0d_instr", i), {instr_valid, instr}, {1'b1, vt[i].word});
      check($sformatf("tbl%0d_le", i), load_enable, vt[i].le);
      if (vt[i].le) check($sformatf("tbl%0d_la", i), load_addr, vt[i].la);
      @(negedge clk);
      check($sformatf("tbl%0d_next", i), {mem_req, mem_addr}, {1'b1, vt[i].next});
    end

    // Randomized program, random misses and conditions, against an instruction-trace model
    for (int i = 0; i < 32768; i++) begin
      case ($urandom_range(0, 7))
        0: mem[i] = {4'hF, 12'($urandom)};
        1: mem[i] = {4'hE, 12'($urandom)};
        default: mem[i] = {4'($urandom_range(0, 13)), 12'($urandom)};
      endcase
    end
    cond_flag = 1'b0;
    restart();
    exp_addr = '0;
    exp_bc = 0;
    gap = 0;
    max_gap = 0;
    pe_seen = 1'b0;
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      if (instr_valid) begin
        w = mem[exp_addr];
        tk = (w[15:12] == 4'hF) || ((w[15:12] == 4'hE) && cond_flag);
        check("rand_instr", instr, w);
        check("rand_load", {load_enable, tk ? load_addr : 16'h0}, {tk, tk ? {4'h0, w[11:0]} : 16'h0});
        if (tk) begin
          exp_addr = {3'b0, w[11:0]};
          exp_bc++;
        end else begin
          exp_addr = exp_addr + 15'd1;
        end
        gap = 0;
      end else begin
        gap++;
        if (gap > max_gap) max_gap = gap;
      end
      if (phase_err) pe_seen = 1'b1;
      cond_flag = 1'($urandom_range(0, 1));
      mem_ready = ($urandom_range(0, 9) < 7);
    end
    check("rand_liveness", max_gap < 40, 1'b1);
    check("rand_no_phase_err", pe_seen, 1'b0);
    check("rand_bcount", branch_count, BC_EN ? 16'(exp_bc) : 16'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
